// File: rtl/msk_aes_128bits_inv_ks.sv
// Masked, bitsliced AES-128 inverse key schedule: walks a d-share round-10 key back to round 0.
// Every value stays split into d shares; only the public rcon constant is unshared.

// d-share AES S-box. The inverse is x^254, built from four ISW multiplications, one per pipeline stage.
module gen_bp_sbox #(
  parameter int d     = 2,
  parameter int n_rnd = d * (d - 1) / 2  // fresh random bytes per masked multiplication
) (
  input  logic                clk,
  input  logic [8*d-1:0]      sh_in,
  input  logic [8*n_rnd-1:0]  rnd0,
  input  logic [8*n_rnd-1:0]  rnd1,
  input  logic [16*n_rnd-1:0] rnd2,
  output logic [8*d-1:0]      sh_out
);
  typedef logic [d-1:0][7:0] shares_t;

  function automatic shares_t unslice(input logic [8*d-1:0] v);
    shares_t s;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < d; k++)
        s[k][b] = v[b*d + k];
    return s;
  endfunction

  function automatic logic [8*d-1:0] slice(input shares_t s);
    logic [8*d-1:0] v;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < d; k++)
        v[b*d + k] = s[k][b];
    return v;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Squaring is GF(2)-linear, so it is applied to each share on its own.
  function automatic shares_t sq(input shares_t a);
    shares_t r;
    for (int k = 0; k < d; k++) r[k] = gf_mul(a[k], a[k]);
    return r;
  endfunction

  function automatic shares_t isw_mul(input shares_t a, input shares_t b,
                                      input logic [8*n_rnd-1:0] r);
    shares_t c;
    int      idx;
    idx = 0;
    for (int i = 0; i < d; i++) c[i] = gf_mul(a[i], b[i]);
    for (int i = 0; i < d; i++)
      for (int j = i + 1; j < d; j++) begin
        c[i] = c[i] ^ r[8*idx +: 8];
        c[j] = c[j] ^ ((r[8*idx +: 8] ^ gf_mul(a[i], b[j])) ^ gf_mul(a[j], b[i]));
        idx++;
      end
    return c;
  endfunction

  function automatic logic [7:0] affine_lin(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
  endfunction

  shares_t x, x2, x12, x240, sb;
  shares_t x3_q, x2_q1, x15_q, x12_q, x2_q2, x252_q, x2_q3, inv_q;

  assign x    = unslice(sh_in);
  assign x2   = sq(x);
  assign x12  = sq(sq(x3_q));
  assign x240 = sq(sq(sq(sq(x15_q))));

  // NOTE: pure datapath pipeline with no reset; its contents only matter once the input has been held stable for four cycles.
  // NOTE: non-blocking assignments let every stage read the previous stage's old value on the same edge.
  always_ff @(posedge clk) begin
    x3_q   <= isw_mul(x2, x, rnd0);
    x2_q1  <= x2;
    x15_q  <= isw_mul(x12, x3_q, rnd1);
    x12_q  <= x12;
    x2_q2  <= x2_q1;
    x252_q <= isw_mul(x240, x12_q, rnd2[8*n_rnd-1:0]);
    x2_q3  <= x2_q2;
    inv_q  <= isw_mul(x252_q, x2_q3, rnd2[16*n_rnd-1:8*n_rnd]);
  end

  // NOTE: sb gets a full default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    sb = inv_q;
    for (int k = 0; k < d; k++) sb[k] = affine_lin(inv_q[k]);
    sb[0] = sb[0] ^ 8'h63;
  end

  assign sh_out = slice(sb);
endmodule

module msk_aes_128bits_inv_ks #(
  parameter int d        = 2,
  parameter int LATENCY  = 4,
  parameter int rnd_bus0 = 4 * d * (d - 1),
  parameter int rnd_bus1 = 4 * d * (d - 1),
  parameter int rnd_bus2 = 8 * d * (d - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [128*d-1:0]      sh_key_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [128*d-1:0]      sh_key_out,
  output logic [3:0]            out_round,
  input  logic [4*rnd_bus0-1:0] rnd_bus0w,
  input  logic [4*rnd_bus1-1:0] rnd_bus1w,
  input  logic [4*rnd_bus2-1:0] rnd_bus2w
);
  localparam int cnt_w  = $clog2(LATENCY + 1);
  localparam int byte_w = 8 * d;
  localparam int col_w  = 32 * d;

  typedef enum logic [1:0] {IDLE, EMIT, COMPUTE} state_t;

  state_t             state;
  logic [128*d-1:0]   key;
  logic [7:0]         rcon;
  logic [3:0]         round;
  logic [cnt_w-1:0]   cnt;
  logic [col_w-1:0]   p1, p2, p3, t_word, sb_out;
  logic [128*d-1:0]   prev_key;

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
  endfunction

  assign p3 = key[3*col_w +: col_w] ^ key[2*col_w +: col_w];
  assign p2 = key[2*col_w +: col_w] ^ key[1*col_w +: col_w];
  assign p1 = key[1*col_w +: col_w] ^ key[0 +: col_w];

  // The S-boxes see a stable key for the whole COMPUTE phase, so any LATENCY >= 4 yields valid outputs.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    gen_bp_sbox #(.d(d)) u_sbox (
      .clk    (clk),
      .sh_in  (p3[i*byte_w +: byte_w]),
      .rnd0   (rnd_bus0w[i*rnd_bus0 +: rnd_bus0]),
      .rnd1   (rnd_bus1w[i*rnd_bus1 +: rnd_bus1]),
      .rnd2   (rnd_bus2w[i*rnd_bus2 +: rnd_bus2]),
      .sh_out (sb_out[i*byte_w +: byte_w])
    );
  end

  // RotWord on the S-box outputs, then rcon folded into share 0 of row 0 only.
  always_comb begin
    t_word = '0;
    for (int r = 0; r < 4; r++)
      t_word[r*byte_w +: byte_w] = sb_out[((r + 1) % 4)*byte_w +: byte_w];
    for (int b = 0; b < 8; b++)
      t_word[b*d] = t_word[b*d] ^ rcon[b];
  end

  assign prev_key   = {p3, p2, p1, key[0 +: col_w] ^ t_word};
  assign sh_key_out = key;
  assign out_round  = round;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      key       <= '0;
      round     <= '0;
      rcon      <= 8'h36;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          key       <= sh_key_in;
          round     <= 4'd10;
          rcon      <= 8'h36;
          state     <= EMIT;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          if (round == 4'd0) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            cnt   <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cnt == cnt_w'(LATENCY)) begin
            key       <= prev_key;
            round     <= round - 4'd1;
            rcon      <= inv_xtime(rcon);
            state     <= EMIT;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msk_aes_128bits_inv_ks.sv
// Scoreboard bench for msk_aes_128bits_inv_ks: random sharings in, recombined round keys checked
// against a word-level FIPS-197 key expansion run backwards.
module tb_msk_aes_128bits_inv_ks;
  localparam int D   = 2;
  localparam int RB0 = 4 * D * (D - 1);
  localparam int RB1 = 4 * D * (D - 1);
  localparam int RB2 = 8 * D * (D - 1);
  localparam int W   = 128 * D;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   sh_key_in, sh_key_out;
  logic [3:0]     out_round;
  logic [4*RB0-1:0] rnd_bus0w;
  logic [4*RB1-1:0] rnd_bus1w;
  logic [4*RB2-1:0] rnd_bus2w;

  msk_aes_128bits_inv_ks #(.d(D), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .sh_key_in(sh_key_in),
    .out_valid(out_valid), .out_ready(out_ready), .sh_key_out(sh_key_out),
    .out_round(out_round),
    .rnd_bus0w(rnd_bus0w), .rnd_bus1w(rnd_bus1w), .rnd_bus2w(rnd_bus2w)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] key; int round; } exp_t;
  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           stall_cycles = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [11];
  logic [127:0] obs_key [11];
  logic [W-1:0] last_r0_sh;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return gmul(a, 8'h02);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Runs the FIPS-197 recurrence w[i] = w[i-4] ^ temp(w[i-1]) backwards from w[40..43].
  task automatic build_model(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc [11];
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc[j] = xtime(rc[j-1]);
    for (int c = 0; c < 4; c++) w[40 + c] = k10[127 - 32*c -: 32];
    for (int i = 43; i >= 4; i--) begin
      temp = w[i-1];
      if (i % 4 == 0) temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc[i/4], 24'h0};
      w[i-4] = w[i] ^ temp;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [W-1:0] share_key(input logic [127:0] k);
    logic [W-1:0] v;
    logic [7:0]   s, acc;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      acc = k[127 - 8*i -: 8];
      for (int sh = 1; sh < D; sh++) begin
        s   = 8'($urandom);
        acc = acc ^ s;
        for (int b = 0; b < 8; b++) v[8*D*i + b*D + sh] = s[b];
      end
      for (int b = 0; b < 8; b++) v[8*D*i + b*D] = acc[b];
    end
    return v;
  endfunction

  function automatic logic [127:0] recombine(input logic [W-1:0] v);
    logic [127:0] k;
    k = '0;
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 8; b++)
        for (int sh = 0; sh < D; sh++)
          k[127 - 8*i - 7 + b] = k[127 - 8*i - 7 + b] ^ v[8*D*i + b*D + sh];
    return k;
  endfunction

  // ---------------- drivers ----------------
  initial begin
    forever begin
      for (int i = 0; i < 4*RB0; i++) rnd_bus0w[i] = 1'($urandom);
      for (int i = 0; i < 4*RB1; i++) rnd_bus1w[i] = 1'($urandom);
      for (int i = 0; i < 4*RB2; i++) rnd_bus2w[i] = 1'($urandom);
      @(posedge clk);
      #1;
    end
  end

  initial begin
    int held;
    held      = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (held < ((out_round != 4'd0) ? stall_cycles : 0)) begin
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        held      = 0;
        out_ready = 1'($urandom);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_valid=1 round %0d, expected no output", out_round);
      end else begin
        check($sformatf("key_r%0d", exp_q[0].round), recombine(sh_key_out), exp_q[0].key);
        check($sformatf("round_r%0d", exp_q[0].round), 128'(out_round), 128'(exp_q[0].round));
        if (out_ready) begin
          obs_key[exp_q[0].round] = recombine(sh_key_out);
          if (exp_q[0].round == 0) last_r0_sh = sh_key_out;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_expected(input logic [127:0] k10);
    build_model(k10);
    for (int r = 10; r >= 0; r--) exp_q.push_back('{key: model_rk[r], round: r});
  endtask

  task automatic accept_key(input logic [127:0] k10, input bit noise);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    sh_key_in = share_key(k10);
    @(posedge clk);
    #1;
    if (noise) sh_key_in = share_key(~k10);
    else in_valid = 1'b0;
  endtask

  task automatic run_walk(input logic [127:0] k10, input int stall, input bit noise,
                          input string tag);
    int n, c10, c9;
    bit done;
    stall_cycles = stall;
    for (int r = 0; r <= 10; r++) obs_key[r] = '0;
    push_expected(k10);
    accept_key(k10, noise);
    n = 0; c10 = -1; c9 = -1; done = 1'b0;
    while (!done && n < 1000) begin
      @(negedge clk);
      if (out_valid && out_round == 4'd10 && c10 < 0) c10 = n + 1;
      if (out_valid && out_round == 4'd9 && c9 < 0) c9 = n + 1;
      done = out_valid && out_ready && out_round == 4'd0;
      if (noise) begin
        if (out_valid && out_round == 4'd0) in_valid = 1'b0;
        else sh_key_in = share_key(~k10 ^ 128'(n));
      end
      @(posedge clk);
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_walk_cycles"}, 128'(n), 128'(61 + 10*stall));
    check({tag, "_key10_cycle"}, 128'(c10), 128'(1));
    if (stall == 0) check({tag, "_key9_cycle"}, 128'(c9), 128'(7));
    @(negedge clk);
    check({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
    check({tag, "_all_keys_seen"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] k;
    logic [W-1:0] prev_sh;
    int n;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sbox_tab[x] = s ^ 8'h63;
    end

    rst = 1'b1; in_valid = 1'b0; sh_key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_round", 128'(out_round), 128'(0));
    check("reset_key", 128'(sh_key_out), 128'(0));
    rst = 1'b0;

    k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    run_walk(k, 0, 1'b0, "fips");
    check("fips_round9_key", obs_key[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_round0_key", obs_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_walk(k, 7, 1'b0, "backpressure");
    check("backpressure_round0_key", obs_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_walk({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, "in_valid_noise");

    for (int t = 0; t < 3; t++)
      run_walk({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0, "random");

    k = {$urandom, $urandom, $urandom, $urandom};
    prev_sh = '0;
    for (int t = 0; t < 50; t++) begin
      run_walk(k, 0, 1'b0, "sharing");
      if (t > 0) begin
        checks++;
        if (last_r0_sh == prev_sh) begin
          errors++;
          $display("FAIL share_diff_run%0d: got identical round-0 shares %0h, expected a fresh sharing", t, last_r0_sh);
        end
      end
      prev_sh = last_r0_sh;
    end

    stall_cycles = 0;
    k = {$urandom, $urandom, $urandom, $urandom};
    push_expected(k);
    accept_key(k, 1'b0);
    n = 0;
    while (!(out_valid && out_ready && out_round == 4'd6) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_round6", 128'(out_round), 128'(6));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_in_ready", 128'(in_ready), 128'(1));
    repeat (20) @(negedge clk);
    run_walk(128'h0, 0, 1'b0, "after_reset_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no summary after 80000 cycles, expected completion");
    $fatal(1);
  end
endmodule
